// File: rtl/instr_loader.sv
// Byte-serial program loader: receives a framed byte stream
// (LEN_HI, LEN_LO, N x {hi,lo}, CHK), writes each 16-bit word into
// instruction memory, and holds the core in reset until a complete,
// checksum-verified program has landed.
module instr_loader #(
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int TIMEOUT = 1000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  input  logic [7:0]        RxData,
  input  logic              RxValid,
  output logic              RxReady,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [15:0]       MemData,
  output logic              MemWEn,
  output logic              CpuHold,
  output logic              Done,
  output logic              Err
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHK, DONE, ERR
  } state_t;

  state_t            state, stateNext;
  logic [7:0]        lenHi, lenHiNext;
  logic [15:0]       wordCnt, wordCntNext;
  logic [7:0]        hiByte, hiByteNext;
  logic [ADDR_W-1:0] wordIdx, wordIdxNext;
  logic [7:0]        acc, accNext;
  logic [TO_W-1:0]   toCnt, toCntNext;

  logic              rxReadyNext;
  logic [ADDR_W-1:0] memAddrNext;
  logic [15:0]       memDataNext;
  logic              memWEnNext;
  logic              cpuHoldNext;
  logic              doneNext;
  logic              errNext;

  logic              accept;
  logic              byteState;
  logic              timedOut;
  logic              lastWord;
  logic [15:0]       lenWord;

  // RxReady is a registered copy of "in a byte-receiving state", so the
  // handshake can be evaluated directly against the output.
  assign accept    = RxValid && RxReady;
  assign byteState = (state == LEN_HI) || (state == LEN_LO) ||
                     (state == DATA_HI) || (state == DATA_LO) ||
                     (state == CHK);
  assign timedOut  = byteState && !accept && (toCnt == TO_LAST);
  assign lastWord  = (32'(wordIdx) + 32'd1) == 32'(wordCnt);
  assign lenWord   = {lenHi, RxData};

  // State, frame bookkeeping and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      lenHi   <= '0;
      wordCnt <= '0;
      hiByte  <= '0;
      wordIdx <= '0;
      acc     <= '0;
      toCnt   <= '0;
      RxReady <= 1'b0;
      MemAddr <= '0;
      MemData <= '0;
      MemWEn  <= 1'b0;
      CpuHold <= 1'b1;
      Done    <= 1'b0;
      Err     <= 1'b0;
    end else begin
      state   <= stateNext;
      lenHi   <= lenHiNext;
      wordCnt <= wordCntNext;
      hiByte  <= hiByteNext;
      wordIdx <= wordIdxNext;
      acc     <= accNext;
      toCnt   <= toCntNext;
      RxReady <= rxReadyNext;
      MemAddr <= memAddrNext;
      MemData <= memDataNext;
      MemWEn  <= memWEnNext;
      CpuHold <= cpuHoldNext;
      Done    <= doneNext;
      Err     <= errNext;
    end
  end

  // Next-state, datapath updates and output decode of the next state.
  always_comb begin
    stateNext   = state;
    lenHiNext   = lenHi;
    wordCntNext = wordCnt;
    hiByteNext  = hiByte;
    wordIdxNext = wordIdx;
    accNext     = acc;
    toCntNext   = toCnt;
    memAddrNext = MemAddr;
    memDataNext = MemData;

    // Checksum covers every frame byte except CHK itself.
    if (accept && (state != CHK)) begin
      accNext = acc ^ RxData;
    end

    // Idle-link watchdog: cleared by any accepted byte, frozen in WRITE.
    if (byteState) begin
      if (accept) begin
        toCntNext = '0;
      end else if (!timedOut) begin
        toCntNext = toCnt + TO_W'(1);
      end
    end

    case (state)
      IDLE, DONE, ERR: begin
        if (Start) begin
          stateNext   = LEN_HI;
          accNext     = '0;
          wordIdxNext = '0;
          toCntNext   = '0;
        end
      end
      LEN_HI: begin
        if (accept) begin
          lenHiNext = RxData;
          stateNext = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          wordCntNext = lenWord;
          if ({16'd0, lenWord} > 32'(DEPTH)) begin
            stateNext = ERR;
          end else if (lenWord == 16'd0) begin
            stateNext = CHK;
          end else begin
            stateNext = DATA_HI;
          end
        end
      end
      DATA_HI: begin
        if (accept) begin
          hiByteNext = RxData;
          stateNext  = DATA_LO;
        end
      end
      DATA_LO: begin
        if (accept) begin
          memDataNext = {hiByte, RxData};
          memAddrNext = wordIdx;
          stateNext   = WRITE;
        end
      end
      WRITE: begin
        // The index never advances past N-1, which bounds MemAddr below DEPTH.
        if (lastWord) begin
          stateNext = CHK;
        end else begin
          wordIdxNext = wordIdx + ADDR_W'(1);
          stateNext   = DATA_HI;
        end
      end
      CHK: begin
        if (accept) begin
          stateNext = (RxData == acc) ? DONE : ERR;
        end
      end
      default: stateNext = IDLE;
    endcase

    if (timedOut) begin
      stateNext = ERR;
    end

    rxReadyNext = (stateNext == LEN_HI) || (stateNext == LEN_LO) ||
                  (stateNext == DATA_HI) || (stateNext == DATA_LO) ||
                  (stateNext == CHK);
    memWEnNext  = (stateNext == WRITE);
    doneNext    = (stateNext == DONE);
    errNext     = (stateNext == ERR);
    cpuHoldNext = (stateNext != DONE);
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Byte-serial program loader that fills the instruction memory the multicycle control/datapath fetches from.
- It is the writer end of the instruction-memory interface.
- It receives a framed byte stream (length, 16-bit instruction words, checksum) over a valid/ready link and writes each word to memory.
- It holds the processor core in reset (CpuHold) until a complete, checksum-verified program has been written.

Parameters:
ADDR_W, 8, instruction memory address width
DEPTH, 256, number of instruction words; max accepted length
TIMEOUT, 1000, max cycles allowed between accepted bytes while loading

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-high
Start  input  1  one-cycle pulse: begin a new load
RxData  input  8  incoming byte
RxValid  input  1  RxData valid
RxReady  output  1  loader can accept a byte
MemAddr  output  ADDR_W  instruction memory write address
MemData  output  16  instruction word: {OpCode[15:12], fields[11:0]}
MemWEn  output  1  instruction memory write enable
CpuHold  output  1  drives core RST; 1 = core held
Done  output  1  load completed, checksum good
Err  output  1  load aborted (length, checksum, timeout)

Behaviour:
- Reset is asynchronous: state=IDLE, RxReady=0, MemWEn=0, MemAddr=0, MemData=0, CpuHold=1, Done=0, Err=0, all counters and accumulators cleared.
- All outputs are registered.
- Byte handshake: a byte is accepted on the rising edge where RxValid=1 and RxReady=1.
- Frame format, bytes in order: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N words sent MSB byte first, then CHK.
- CHK = XOR of every preceding frame byte, including both length bytes.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHK, DONE, ERR.
- IDLE/DONE/ERR + Start: go to LEN_HI. Clear Done, Err, the XOR accumulator, the word index and the timeout counter. Set CpuHold=1.
- Start is ignored in every other state.
- RxReady=1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHK.
- LEN_LO accept, after N is formed:
  - N > DEPTH: go to ERR.
  - N == 0: go to CHK.
  - Otherwise: go to DATA_HI.
- DATA_HI accept: latch the upper byte, go to DATA_LO.
- DATA_LO accept: latch the lower byte, go to WRITE.
- WRITE lasts exactly 1 cycle:
  - MemWEn=1, MemAddr=index, MemData=assembled word; RxReady=0.
  - If index == N-1, go to CHK; otherwise increment index and go to DATA_HI.
  - MemWEn is 0 in every other state.
- Each accepted byte updates the accumulator: acc <= acc ^ byte. The CHK byte itself is not accumulated.
- CHK accept: byte == acc goes to DONE, otherwise to ERR.
- DONE: Done=1, CpuHold=0. Stay until Start.
- ERR: Err=1, CpuHold=1. Stay until Start.
- Timeout counter:
  - Resets on every accepted byte and on entry to LEN_HI.
  - Increments each cycle in any byte-receiving state with no accept.
  - Reaching TIMEOUT-1 goes to ERR.
  - Frozen in WRITE.
- Words already written before an error stay in memory. The core remains held.
- CpuHold rises in the same cycle as the Start-triggered transition and falls on entry to DONE.
- Reset mid-load aborts immediately; no further memory writes occur.
- MemAddr wraps only through the index limit; it can never exceed DEPTH-1.

Test Plan:
- Load 2 words: Start, then bytes 00 02 04 32 9A 15 BB. Expect writes (addr 0, 0x0432) and (addr 1, 0x9A15), one MemWEn pulse each. Then Done=1, CpuHold=0, Err=0.
- Empty program: bytes 00 00 00. Expect no MemWEn, Done=1, CpuHold=0.
- Bad checksum: same frame as the first case with CHK=0xBA. Both words are written, then Err=1, CpuHold=1, Done=0. A following Start plus a good frame yields Done=1.
- Oversize length: with DEPTH=256, send 01 01. Expect Err=1 right after LEN_LO, no writes, RxReady=0.
- Timeout: send 00 02 04 and then stop RxValid. Expect Err=1 exactly TIMEOUT cycles after the last accept. Toggling RxValid in the WRITE cycle is never accepted (RxReady=0).
- Async reset mid-load: assert RST between clock edges after byte 04. All outputs go to reset values immediately, CpuHold=1, no further MemWEn. A Start after release begins a new frame.
